// File: rtl/iob_dbus2axil_pkg.sv
// Shared definitions for the native-bus to AXI4-Lite bridge.
// Holds the FSM state encoding and the AXI response code constants.
// Imported by iob_dbus2axil.
package iob_dbus2axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Any non-OKAY response is reported to the native master as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/iob_dbus2axil.sv
// Purpose: bridges a native valid/ready request bus to an AXI4-Lite master, one transaction at a time.
// Latency: zero-wait slave -> iob_ready 4 cycles after the accepting cycle, for both reads and writes.
// Backpressure: AXI valids held with stable payload until handshake; no new request until iob_ready pulses.
//
// Ports: clk/rst (async active-low); native side iob_valid/iob_addr/iob_wdata/iob_wstrb in,
// iob_rdata/iob_ready/iob_err out; AXI4-Lite master channels AW, W, B, AR, R with prot tied to 0.
module iob_dbus2axil
    import iob_dbus2axil_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // native request side
    input  logic                  iob_valid,
    input  logic [ADDR_W-1:0]     iob_addr,
    input  logic [DATA_W-1:0]     iob_wdata,
    input  logic [DATA_W/8-1:0]   iob_wstrb,
    output logic [DATA_W-1:0]     iob_rdata,
    output logic                  iob_ready,
    output logic                  iob_err,
    // AXI4-Lite write address
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [2:0]            awprot,
    // AXI4-Lite write data
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    // AXI4-Lite write response
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    // AXI4-Lite read address
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_W-1:0]     araddr,
    output logic [2:0]            arprot,
    // AXI4-Lite read data
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp
);

    localparam int STRB_W = DATA_W / 8;

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [STRB_W-1:0]   wstrb_q,     wstrb_d;
    logic [DATA_W-1:0]   iob_rdata_q, iob_rdata_d;
    logic                iob_ready_q, iob_ready_d;
    logic                iob_err_q,   iob_err_d;
    logic                awvalid_q,   awvalid_d;
    logic                wvalid_q,    wvalid_d;
    logic                bready_q,    bready_d;
    logic                arvalid_q,   arvalid_d;
    logic                rready_q,    rready_d;
    // AW and W complete independently; these remember which one already fired.
    logic                aw_done_q,   aw_done_d;
    logic                w_done_q,    w_done_d;

    logic aw_fire;
    logic w_fire;

    assign aw_fire = awvalid_q & awready;
    assign w_fire  = wvalid_q  & wready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        iob_rdata_d = iob_rdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        iob_ready_d = 1'b0;
        iob_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iob_valid) begin
                    addr_d  = iob_addr;
                    wdata_d = iob_wdata;
                    wstrb_d = iob_wstrb;
                    state_d = (iob_wstrb != '0) ? ST_WR : ST_RD_ADDR;
                end
            end

            ST_WR: begin
                // First cycle in WR launches both channels from the captured request.
                if (!awvalid_q && !wvalid_q && !aw_done_q && !w_done_q) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else begin
                    if (aw_fire) begin
                        awvalid_d = 1'b0;
                        aw_done_d = 1'b1;
                    end
                    if (w_fire) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end
                    if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        bready_d  = 1'b1;
                        state_d   = ST_WR_RESP;
                    end
                end
            end

            ST_WR_RESP: begin
                if (bvalid) begin
                    bready_d    = 1'b0;
                    iob_ready_d = 1'b1;
                    iob_err_d   = resp_is_err(bresp);
                    state_d     = ST_DONE;
                end
            end

            ST_RD_ADDR: begin
                if (!arvalid_q) begin
                    arvalid_d = 1'b1;
                end else if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                // Error responses still deliver their data.
                if (rvalid) begin
                    rready_d    = 1'b0;
                    iob_rdata_d = rdata;
                    iob_ready_d = 1'b1;
                    iob_err_d   = resp_is_err(rresp);
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                // iob_ready is high this cycle; iob_valid is deliberately not looked at.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            iob_rdata_q <= '0;
            iob_ready_q <= 1'b0;
            iob_err_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            iob_rdata_q <= iob_rdata_d;
            iob_ready_q <= iob_ready_d;
            iob_err_q   <= iob_err_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

    assign iob_rdata = iob_rdata_q;
    assign iob_ready = iob_ready_q;
    assign iob_err   = iob_err_q;
    assign awvalid   = awvalid_q;
    assign awaddr    = addr_q;
    assign awprot    = 3'b000;
    assign wvalid    = wvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign bready    = bready_q;
    assign arvalid   = arvalid_q;
    assign araddr    = addr_q;
    assign arprot    = 3'b000;
    assign rready    = rready_q;

endmodule

// File: tb/tb_iob_dbus2axil.sv
// Bench for iob_dbus2axil: directed native requests against a configurable AXI4-Lite slave.
// Expected completion cycles, error flags and held read data come from a cycle-arithmetic model.
// The slave counts handshakes and checks payload stability while valids wait.
module tb_iob_dbus2axil;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iob_valid = 1'b0;
    logic [31:0] iob_addr = '0;
    logic [31:0] iob_wdata = '0;
    logic [3:0]  iob_wstrb = '0;
    logic [31:0] iob_rdata;
    logic        iob_ready, iob_err;
    logic        awvalid, awready = 1'b0;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid = 1'b0, bready;
    logic [1:0]  bresp = 2'b00;
    logic        arvalid, arready = 1'b0;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid = 1'b0, rready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;

    iob_dbus2axil #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .iob_valid(iob_valid), .iob_addr(iob_addr), .iob_wdata(iob_wdata), .iob_wstrb(iob_wstrb),
        .iob_rdata(iob_rdata), .iob_ready(iob_ready), .iob_err(iob_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // ---------------- model state ----------------
    bit          exp_rdy[int];
    bit          exp_err_at[int];
    logic [31:0] model_rdata = '0;
    int          last_done = -10;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic [3:0]  exp_wstrb = '0;

    // ---------------- slave configuration ----------------
    int          cfg_awd = 0, cfg_wd = 0, cfg_bd = 0, cfg_ard = 0, cfg_rd = 0;
    logic [1:0]  cfg_resp = 2'b00;
    logic [31:0] cfg_rdata = '0;

    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int aw_hs_cyc = 0, w_hs_cyc = 0;
    logic [31:0] ar_last = '0;

    // ---------------- AXI4-Lite slave, driven on the falling edge ----------------
    initial begin
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        bit aw_got, w_got, r_pend;
        logic p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [3:0]  p_wstrb;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; r_pend = 0;
        p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
        p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_wstrb = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; r_pend = 0;
                p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
            end else begin
                // handshakes that happened at the rising edge just passed
                if (p_awvalid && awready) begin
                    aw_hs++; aw_hs_cyc = cyc - 1; aw_got = 1; aw_cnt = 0;
                    chk("awaddr", p_awaddr, exp_addr);
                end else if (p_awvalid) begin
                    chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
                end
                if (p_wvalid && wready) begin
                    w_hs++; w_hs_cyc = cyc - 1; w_got = 1; w_cnt = 0;
                    chk("wdata", {p_wdata, p_wstrb}, {exp_wdata, exp_wstrb});
                end else if (p_wvalid) begin
                    chk("w_hold", {wvalid, wdata, wstrb}, {1'b1, p_wdata, p_wstrb});
                end
                if (bvalid && p_bready) begin
                    bvalid = 0; b_hs++;
                end
                if (p_arvalid && arready) begin
                    ar_hs++; ar_last = p_araddr; r_pend = 1; r_cnt = 0; ar_cnt = 0;
                    chk("araddr", p_araddr, exp_addr);
                end else if (p_arvalid) begin
                    chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
                end
                if (rvalid && p_rready) begin
                    rvalid = 0; r_hs++;
                end
                // drive for the coming rising edge
                awready = awvalid && (aw_cnt == cfg_awd);
                if (awvalid && !awready) aw_cnt++;
                wready = wvalid && (w_cnt == cfg_wd);
                if (wvalid && !wready) w_cnt++;
                if (aw_got && w_got) begin
                    if (b_cnt == cfg_bd) begin
                        bvalid = 1; bresp = cfg_resp; aw_got = 0; w_got = 0; b_cnt = 0;
                    end else b_cnt++;
                end
                arready = arvalid && (ar_cnt == cfg_ard);
                if (arvalid && !arready) ar_cnt++;
                if (r_pend) begin
                    if (r_cnt == cfg_rd) begin
                        rvalid = 1; rresp = cfg_resp; rdata = cfg_rdata; r_pend = 0;
                    end else r_cnt++;
                end
                p_awvalid = awvalid; p_awaddr = awaddr;
                p_wvalid = wvalid; p_wdata = wdata; p_wstrb = wstrb;
                p_bready = bready;
                p_arvalid = arvalid; p_araddr = araddr;
                p_rready = rready;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial begin
        bit er;
        forever begin
            @(negedge clk);
            #3;
            er = exp_rdy.exists(cyc);
            chk("iob_ready", iob_ready, er);
            chk("iob_err", iob_err, er ? exp_err_at[cyc] : 1'b0);
            chk("iob_rdata", iob_rdata, model_rdata);
            chk("prot", {awprot, arprot}, 6'd0);
        end
    end

    // ---------------- request driver; called at falling edge + 1 ----------------
    task automatic run_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input int awd, input int wdl, input int bd, input int ard, input int rdl,
                           input logic [1:0] resp, input logic [31:0] srd,
                           output int lat, output logic err_seen);
        int t0, done;
        int aw0, w0, b0, ar0, r0;
        bit is_wr;
        cfg_awd = awd; cfg_wd = wdl; cfg_bd = bd; cfg_ard = ard; cfg_rd = rdl;
        cfg_resp = resp; cfg_rdata = srd;
        exp_addr = a; exp_wdata = wd; exp_wstrb = ws;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
        is_wr = (ws != 4'd0);
        // a request presented while the bridge is in its completion cycle waits one cycle
        t0 = (last_done == cyc) ? cyc + 1 : cyc;
        done = t0 + 4 + (is_wr ? ((awd > wdl ? awd : wdl) + bd) : (ard + rdl));
        exp_rdy[done] = 1'b1;
        exp_err_at[done] = (resp != 2'b00);
        iob_valid = 1'b1; iob_addr = a; iob_wdata = wd; iob_wstrb = ws;
        lat = -1; err_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (cyc == done && !is_wr) model_rdata = srd;
            if (iob_ready && lat < 0) begin
                lat = cyc - t0; err_seen = iob_err;
            end
            if (lat >= 0 && cyc >= done) break;
        end
        chk("latency_model", lat, done - t0);
        last_done = done;
        iob_valid = 1'b0;
        chk("handshake_counts", {aw_hs - aw0, w_hs - w0, b_hs - b0, ar_hs - ar0, r_hs - r0},
            {is_wr ? 32'd1 : 32'd0, is_wr ? 32'd1 : 32'd0, is_wr ? 32'd1 : 32'd0,
             is_wr ? 32'd0 : 32'd1, is_wr ? 32'd0 : 32'd1});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic e;
        // reset state
        idle(2);
        chk("rst_outputs", {awvalid, wvalid, bready, arvalid, rready, iob_ready, iob_err}, 7'd0);
        chk("rst_rdata", iob_rdata, 32'd0);
        chk("rst_addr", {awaddr, araddr, wdata, wstrb}, 100'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // zero-wait read
        run_req(32'h0000_1000, 32'h0, 4'b0000, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, lat, e);
        chk("rd_latency", lat, 4);
        chk("rd_data", iob_rdata, 32'hDEAD_BEEF);
        chk("rd_err", e, 1'b0);
        chk("rd_araddr", ar_last, 32'h0000_1000);

        // write with AW accepted 3 cycles after W
        idle(2);
        run_req(32'h20, 32'h1234_5678, 4'b0011, 3, 0, 0, 0, 0, 2'b00, 32'h0, lat, e);
        chk("wr_aw_after_w", aw_hs_cyc - w_hs_cyc, 3);
        chk("wr_latency", lat, 7);
        chk("wr_keeps_rdata", iob_rdata, 32'hDEAD_BEEF);

        // read with SLVERR
        run_req(32'h40, 32'h0, 4'b0000, 0, 0, 0, 0, 0, 2'b10, 32'hCAFE_0000, lat, e);
        chk("rd_err_flag", e, 1'b1);
        chk("rd_err_data", iob_rdata, 32'hCAFE_0000);

        // write with delayed W and B, error response
        idle(1);
        run_req(32'h44, 32'hA0A0_0B0B, 4'b1000, 0, 2, 2, 0, 0, 2'b11, 32'h0, lat, e);
        chk("wr_err_flag", e, 1'b1);
        chk("wr_err_latency", lat, 8);
        chk("wr_err_keeps_rdata", iob_rdata, 32'hCAFE_0000);

        // back-to-back with iob_valid held high across each completion
        run_req(32'h100, 32'h0, 4'b0000, 0, 0, 0, 0, 1, 2'b00, 32'h1111_1111, lat, e);
        run_req(32'h104, 32'h5555_AAAA, 4'b1111, 1, 1, 0, 0, 0, 2'b00, 32'h0, lat, e);
        run_req(32'h108, 32'h0, 4'b0000, 0, 0, 0, 2, 0, 2'b00, 32'h2222_2222, lat, e);
        chk("b2b_latency", lat, 6);
        chk("b2b_rdata", iob_rdata, 32'h2222_2222);

        // reset while waiting in the write-response state
        idle(2);
        cfg_awd = 0; cfg_wd = 0; cfg_bd = 6;
        exp_addr = 32'h80; exp_wdata = 32'h0BAD_F00D; exp_wstrb = 4'b1111;
        iob_valid = 1'b1; iob_addr = 32'h80; iob_wdata = 32'h0BAD_F00D; iob_wstrb = 4'b1111;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_bready", bready, 1'b1);
        #1;
        rst = 1'b0;
        iob_valid = 1'b0;
        model_rdata = '0;
        #1;
        chk("midrst_outputs", {awvalid, wvalid, bready, arvalid, rready, iob_ready, iob_err}, 7'd0);
        chk("midrst_regs", {iob_rdata, awaddr, wdata, wstrb}, 100'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;

        // normal read after reset
        run_req(32'h0000_1000, 32'h0, 4'b0000, 0, 0, 0, 0, 0, 2'b00, 32'hA5A5_5A5A, lat, e);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_rdata", iob_rdata, 32'hA5A5_5A5A);

        idle(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/iob_dbus2axil.md
IOB_DBUS2AXIL -- requirements
Module: iob_dbus2axil

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; DATA_W/8 strobe bits.
REQ-003 SHALL have clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have rst  input  1  asynchronous reset, active-low (asserted at 0).
REQ-005 SHALL have iob_valid  input  1  native request valid; held by master until iob_ready.
REQ-006 SHALL have iob_addr  input  ADDR_W  request byte address.
REQ-007 SHALL have iob_wdata  input  DATA_W  write data.
REQ-008 SHALL have iob_wstrb  input  DATA_W/8  write strobes; all-zero means read.
REQ-009 SHALL have iob_rdata  output  DATA_W  read data.
REQ-010 SHALL have iob_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have iob_err  output  1  one-cycle error flag, coincident with iob_ready.
REQ-012 SHALL have AXI4-Lite master ports: awvalid/awready/awaddr[ADDR_W], wvalid/wready/wdata[DATA_W]/wstrb[DATA_W/8], bvalid/bready/bresp[2], arvalid/arready/araddr[ADDR_W], rvalid/rready/rdata[DATA_W]/rresp[2], awprot/arprot[3] tied 3'b000.

Function
REQ-013 SHALL implement FSM states IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-014 In IDLE with iob_valid=1 SHALL capture addr/wdata/wstrb into registers; next state WR if wstrb!=0, else RD_ADDR.
REQ-015 In WR SHALL assert awvalid and wvalid from registers; each drops independently on its own handshake; leave WR when both handshakes done (same or different cycles, either order).
REQ-016 In WR_RESP SHALL assert bready; on bvalid go to DONE, latch err = (bresp!=2'b00).
REQ-017 In RD_ADDR SHALL assert arvalid until arready; then RD_DATA.
REQ-018 In RD_DATA SHALL assert rready; on rvalid latch rdata into iob_rdata, err = (rresp!=2'b00); go to DONE.
REQ-019 In DONE SHALL drive iob_ready=1 (and iob_err if latched) for exactly one cycle, ignore iob_valid, return to IDLE.
REQ-020 SHALL never accept a new request before the current one completes; one outstanding transaction maximum.
REQ-021 AXI valids SHALL be registered and, once asserted, held with stable payload until handshake.
REQ-022 Latency with zero-wait slave: read, request cycle 0 -> iob_ready cycle 4; write -> cycle 4.
REQ-023 iob_rdata SHALL hold the last read value until the next read completes; writes do not alter it.
REQ-024 Error responses SHALL still complete the transaction (iob_ready pulses; rdata still latched).
REQ-025 iob_valid deasserted before acceptance SHALL be ignored; request fields sampled only in IDLE.

Reset
REQ-026 On rst=0 (asynchronous) SHALL enter IDLE; all AXI valid/ready outputs, iob_ready, iob_err = 0; iob_rdata, address, data, strobe registers = 0.
REQ-027 Reset mid-transaction SHALL abandon it immediately (no completion pulse); AXI slave must be reset together.
REQ-028 Deassertion SHALL be synchronised externally; block first accepts a request the cycle after rst rises.

Structure
REQ-029 FSM state encodings and AXI response codes (OKAY=2'b00) SHALL live in a shared header included by the module.
REQ-030 SHALL be a single module with no sub-modules; no combinational path from AXI inputs to iob_ready.

Verification
REQ-031 Read, zero-wait slave: addr 0x0000_1000, slave rdata 0xDEAD_BEEF, rresp 0 -> araddr 0x1000 once, iob_ready cycle 4, iob_rdata 0xDEADBEEF, iob_err 0.
REQ-032 Write, awready 3 cycles after wready: addr 0x20, wdata 0x1234_5678, wstrb 4'b0011 -> wvalid drops first, awvalid held 3 cycles, bready then iob_ready once.
REQ-033 Read with rresp=2'b10, rdata 0xCAFE_0000 -> iob_ready and iob_err pulse together, iob_rdata 0xCAFE0000.
REQ-034 iob_valid held high across completion with back-to-back requests -> exactly one AXI transaction per completion, none duplicated in DONE.
REQ-035 rst=0 while in WR_RESP -> all outputs 0 same cycle, no iob_ready; next read after reset completes normally.
REQ-036 Write then read -> iob_rdata unchanged by write, updated only by read.
